// File: rtl/gpio_trace_logger.sv
`default_nettype none
//============================================================================
// Module   : gpio_trace_logger
// Brief    : Timestamps changes on masked GPIO lines into a valid/ready FIFO,
//            with a sticky overflow flag and an inactivity watchdog.
// Revision : 1.0
//============================================================================
module gpio_trace_logger #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 16,
    parameter int TS_WIDTH  = 24,
    parameter int WDT_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [WIDTH-1:0]              gpio_in,
    input  logic [WIDTH-1:0]              mask,
    input  logic [WDT_WIDTH-1:0]          wdt_limit,
    input  logic                          clr,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [WIDTH+TS_WIDTH+1:0]     rd_data,
    output logic [$clog2(DEPTH+1)-1:0]    level,
    output logic                          overflow,
    output logic                          wdt_timeout
);

    localparam int c_ptr_w   = $clog2(DEPTH);
    localparam int c_lvl_w   = $clog2(DEPTH+1);
    localparam int c_entry_w = WIDTH + TS_WIDTH + 2;
    localparam logic [c_lvl_w-1:0] c_full_lvl = c_lvl_w'(DEPTH);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [TS_WIDTH-1:0]   r_ts;
    logic [WIDTH-1:0]      r_prev;
    logic                  r_first;
    logic                  r_lost;
    logic [WDT_WIDTH-1:0]  r_wdt;
    logic                  r_overflow;
    logic                  r_wdt_timeout;
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_lvl_w-1:0]    r_count;
    logic                  r_rd_valid;
    logic [c_entry_w-1:0]  r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Event detection and push/pop decisions
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]      w_cur;
    logic                  w_ts_max;
    logic                  w_change;
    logic                  w_event;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_wdt_max;
    logic [c_entry_w-1:0]  w_entry;
    logic [c_lvl_w-1:0]    w_count_nxt;

    assign w_cur     = gpio_in & mask;
    assign w_ts_max  = &r_ts;
    assign w_change  = r_first | (w_cur != r_prev);
    assign w_event   = en & (w_change | w_ts_max);
    assign w_full    = (r_count == c_full_lvl);
    assign w_pop     = r_rd_valid & rd_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_push    = w_event & (~w_full | w_pop);
    assign w_drop    = w_event & w_full & ~w_pop;
    assign w_wdt_max = &r_wdt;
    assign w_entry   = {r_lost, w_ts_max, r_ts, w_cur};

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_lvl_w'(1);
            2'b01:   w_count_nxt = r_count - c_lvl_w'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // ------------------------------------------------------------------
    // Trace state: timestamp, previous value, first/lost flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts    <= '0;
            r_prev  <= '0;
            r_first <= 1'b1;
            r_lost  <= 1'b0;
        end else begin
            if (en) begin
                r_ts <= r_ts + TS_WIDTH'(1);
            end
            if (!en) begin
                r_first <= 1'b1;
            end else if (w_event) begin
                r_first <= 1'b0;
                r_prev  <= w_cur;
            end
            if (w_push) begin
                r_lost <= 1'b0;
            end else if (w_drop) begin
                r_lost <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count    <= w_count_nxt;
            r_rd_valid <= (w_count_nxt != '0);
        end
    end

    // Storage is not reset; contents are only observable while valid.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags and inactivity watchdog
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdt         <= '0;
            r_overflow    <= 1'b0;
            r_wdt_timeout <= 1'b0;
        end else begin
            if (clr) begin
                r_wdt <= '0;
            end else if (en) begin
                // Wrap-only events are not activity.
                if (w_change) begin
                    r_wdt <= '0;
                end else if (!w_wdt_max) begin
                    r_wdt <= r_wdt + WDT_WIDTH'(1);
                end
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr) begin
                r_overflow <= 1'b0;
            end

            if (clr) begin
                r_wdt_timeout <= 1'b0;
            end else if ((wdt_limit != '0) && (r_wdt >= wdt_limit)) begin
                r_wdt_timeout <= 1'b1;
            end
        end
    end

    assign rd_valid    = r_rd_valid;
    assign rd_data     = r_mem[r_rd_ptr];
    assign level       = r_count;
    assign overflow    = r_overflow;
    assign wdt_timeout = r_wdt_timeout;

endmodule
`default_nettype wire

// File: tb/tb_gpio_trace_logger.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module   : tb_gpio_trace_logger
// Brief    : Directed self-checking bench for gpio_trace_logger.
// Revision : 1.0
//============================================================================
module tb_gpio_trace_logger;

    localparam int WIDTH     = 4;
    localparam int DEPTH     = 16;
    localparam int TS_WIDTH  = 24;
    localparam int WDT_WIDTH = 32;
    localparam int EW        = WIDTH + TS_WIDTH + 2;
    localparam int TSW_S     = 4;
    localparam int EW_S      = WIDTH + TSW_S + 2;
    localparam int LW        = $clog2(DEPTH+1);

    logic                 clk = 1'b0;
    logic                 rst, en, clr, rd_ready;
    logic [WIDTH-1:0]     gpio_in, mask;
    logic [WDT_WIDTH-1:0] wdt_limit;
    logic                 rd_valid, overflow, wdt_timeout;
    logic [EW-1:0]        rd_data;
    logic [LW-1:0]        level;

    logic                 rst_w, en_w, rd_ready_w;
    logic                 rd_valid_w, overflow_w, wdt_timeout_w;
    logic [EW_S-1:0]      rd_data_w;
    logic [LW-1:0]        level_w;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gpio_trace_logger #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH), .WDT_WIDTH(WDT_WIDTH)) u_dut (
        .clk(clk), .rst(rst), .en(en), .gpio_in(gpio_in), .mask(mask),
        .wdt_limit(wdt_limit), .clr(clr), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .level(level), .overflow(overflow), .wdt_timeout(wdt_timeout)
    );

    // Short-timestamp instance for the wrap scenario.
    gpio_trace_logger #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_WIDTH(TSW_S), .WDT_WIDTH(WDT_WIDTH)) u_dut_w (
        .clk(clk), .rst(rst_w), .en(en_w), .gpio_in(gpio_in), .mask(mask),
        .wdt_limit(wdt_limit), .clr(clr), .rd_valid(rd_valid_w), .rd_ready(rd_ready_w),
        .rd_data(rd_data_w), .level(level_w), .overflow(overflow_w), .wdt_timeout(wdt_timeout_w)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] ent(input logic lost, input logic wrap,
                                          input logic [TS_WIDTH-1:0] ts, input logic [WIDTH-1:0] g);
        return {lost, wrap, ts, g};
    endfunction

    function automatic logic [EW_S-1:0] ent_s(input logic lost, input logic wrap,
                                              input logic [TSW_S-1:0] ts, input logic [WIDTH-1:0] g);
        return {lost, wrap, ts, g};
    endfunction

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; clr = 1'b0; rd_ready = 1'b0;
        gpio_in = 4'h0; mask = 4'hF; wdt_limit = '0;
        tick; tick;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (wdt_timeout !== 1'b0) begin errors++; $display("FAIL reset_wdt_timeout: got %b expected 0", wdt_timeout); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [EW-1:0] exp_e [3];
        rst = 1'b1; mask = 4'hF; gpio_in = 4'h0; en = 1'b1; rd_ready = 1'b0; wdt_limit = '0;
        tick; rst = 1'b0;
        repeat (10) tick;
        gpio_in = 4'h5; tick;
        repeat (9) tick;
        gpio_in = 4'hA; tick;
        checks++; if (level !== 5'd3) begin errors++; $display("FAIL basic_level: got %0d expected 3", level); end
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic_rd_valid: got %b expected 1", rd_valid); end
        exp_e[0] = ent(1'b0, 1'b0, 24'd0,  4'h0);
        exp_e[1] = ent(1'b0, 1'b0, 24'd10, 4'h5);
        exp_e[2] = ent(1'b0, 1'b0, 24'd20, 4'hA);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_data !== exp_e[i]) begin errors++; $display("FAIL basic_entry%0d: got %h expected %h", i, rd_data, exp_e[i]); end
            rd_ready = 1'b1; tick; rd_ready = 1'b0;
        end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_drained_valid: got %b expected 0", rd_valid); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL basic_drained_level: got %0d expected 0", level); end
    endtask

    task automatic test_enable;
        rst = 1'b1; mask = 4'hF; gpio_in = 4'h0; en = 1'b1; rd_ready = 1'b0; wdt_limit = '0;
        tick; rst = 1'b0;
        tick;
        en = 1'b0; gpio_in = 4'h7;
        repeat (5) tick;
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL enable_off_level: got %0d expected 1", level); end
        en = 1'b1; tick;
        checks++; if (level !== 5'd2) begin errors++; $display("FAIL enable_on_level: got %0d expected 2", level); end
        checks++; if (rd_data !== ent(1'b0, 1'b0, 24'd0, 4'h0)) begin errors++; $display("FAIL enable_entry0: got %h expected %h", rd_data, ent(1'b0, 1'b0, 24'd0, 4'h0)); end
        rd_ready = 1'b1; tick; rd_ready = 1'b0;
        checks++; if (rd_data !== ent(1'b0, 1'b0, 24'd1, 4'h7)) begin errors++; $display("FAIL enable_entry1: got %h expected %h", rd_data, ent(1'b0, 1'b0, 24'd1, 4'h7)); end
    endtask

    task automatic test_mask;
        rst = 1'b1; mask = 4'h1; gpio_in = 4'h0; en = 1'b1; rd_ready = 1'b0; wdt_limit = 32'd40;
        tick; rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            gpio_in = i[0] ? 4'hE : 4'h0;
            tick;
        end
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL mask_level: got %0d expected 1", level); end
        checks++; if (rd_data !== ent(1'b0, 1'b0, 24'd0, 4'h0)) begin errors++; $display("FAIL mask_entry: got %h expected %h", rd_data, ent(1'b0, 1'b0, 24'd0, 4'h0)); end
        checks++; if (wdt_timeout !== 1'b1) begin errors++; $display("FAIL mask_wdt_timeout: got %b expected 1", wdt_timeout); end
    endtask

    task automatic test_overflow;
        logic [EW-1:0] exp_e;
        rst = 1'b1; mask = 4'hF; gpio_in = 4'h0; en = 1'b1; rd_ready = 1'b0; wdt_limit = '0; clr = 1'b0;
        tick; rst = 1'b0;
        tick;
        for (int i = 1; i <= 20; i++) begin
            gpio_in = 4'(i);
            clr = (i == 20);
            tick;
        end
        clr = 1'b0;
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d expected 16", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag_set_wins: got %b expected 1", overflow); end
        checks++; if (rd_data !== ent(1'b0, 1'b0, 24'd0, 4'h0)) begin errors++; $display("FAIL ovf_head: got %h expected %h", rd_data, ent(1'b0, 1'b0, 24'd0, 4'h0)); end
        rd_ready = 1'b1; tick; rd_ready = 1'b0;
        checks++; if (level !== 5'd15) begin errors++; $display("FAIL ovf_pop_level: got %0d expected 15", level); end
        gpio_in = 4'h5; tick;
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_refill_level: got %0d expected 16", level); end
        clr = 1'b1; tick; clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
        checks++; if (rd_data !== ent(1'b0, 1'b0, 24'd1, 4'h1)) begin errors++; $display("FAIL full_pp_head: got %h expected %h", rd_data, ent(1'b0, 1'b0, 24'd1, 4'h1)); end
        gpio_in = 4'h6; rd_ready = 1'b1; tick;
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_pp_level: got %0d expected 16", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pp_overflow: got %b expected 0", overflow); end
        for (int k = 0; k < 16; k++) begin
            if (k < 14)       exp_e = ent(1'b0, 1'b0, TS_WIDTH'(k + 2), 4'(k + 2));
            else if (k == 14) exp_e = ent(1'b1, 1'b0, 24'd22, 4'h5);
            else              exp_e = ent(1'b0, 1'b0, 24'd24, 4'h6);
            checks++;
            if (rd_data !== exp_e) begin errors++; $display("FAIL ovf_drain%0d: got %h expected %h", k, rd_data, exp_e); end
            tick;
        end
        rd_ready = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained_valid: got %b expected 0", rd_valid); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL ovf_drained_level: got %0d expected 0", level); end
    endtask

    task automatic test_wrap;
        logic [EW_S-1:0] exp_e [3];
        en = 1'b0; gpio_in = 4'h0; mask = 4'hF; wdt_limit = 32'd20; clr = 1'b0;
        rst_w = 1'b1; en_w = 1'b1; rd_ready_w = 1'b0;
        tick; rst_w = 1'b0;
        repeat (15) tick;
        checks++; if (level_w !== 5'd1) begin errors++; $display("FAIL wrap_before_level: got %0d expected 1", level_w); end
        tick;
        checks++; if (level_w !== 5'd2) begin errors++; $display("FAIL wrap_first_level: got %0d expected 2", level_w); end
        repeat (16) tick;
        checks++; if (level_w !== 5'd3) begin errors++; $display("FAIL wrap_second_level: got %0d expected 3", level_w); end
        checks++; if (wdt_timeout_w !== 1'b1) begin errors++; $display("FAIL wrap_wdt_not_reset: got %b expected 1", wdt_timeout_w); end
        exp_e[0] = ent_s(1'b0, 1'b0, 4'd0,  4'h0);
        exp_e[1] = ent_s(1'b0, 1'b1, 4'd15, 4'h0);
        exp_e[2] = ent_s(1'b0, 1'b1, 4'd15, 4'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_data_w !== exp_e[i]) begin errors++; $display("FAIL wrap_entry%0d: got %h expected %h", i, rd_data_w, exp_e[i]); end
            rd_ready_w = 1'b1; tick; rd_ready_w = 1'b0;
        end
        rst_w = 1'b1; en_w = 1'b0;
    endtask

    task automatic test_watchdog_reset;
        rst = 1'b1; mask = 4'hF; gpio_in = 4'h0; en = 1'b1; rd_ready = 1'b0; wdt_limit = 32'd100; clr = 1'b0;
        tick; rst = 1'b0;
        tick;
        repeat (100) tick;
        checks++; if (wdt_timeout !== 1'b0) begin errors++; $display("FAIL wdt_early: got %b expected 0", wdt_timeout); end
        tick;
        checks++; if (wdt_timeout !== 1'b1) begin errors++; $display("FAIL wdt_rise: got %b expected 1", wdt_timeout); end
        clr = 1'b1; tick; clr = 1'b0;
        checks++; if (wdt_timeout !== 1'b0) begin errors++; $display("FAIL wdt_clr: got %b expected 0", wdt_timeout); end
        tick;
        checks++; if (wdt_timeout !== 1'b0) begin errors++; $display("FAIL wdt_after_clr: got %b expected 0", wdt_timeout); end
        wdt_limit = 32'd1; tick; tick;
        checks++; if (wdt_timeout !== 1'b1) begin errors++; $display("FAIL wdt_rerise: got %b expected 1", wdt_timeout); end
        gpio_in = 4'h9; tick;
        checks++; if (level !== 5'd2) begin errors++; $display("FAIL rst_pre_level: got %0d expected 2", level); end
        rst = 1'b1; gpio_in = 4'h3; tick;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", rd_valid); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL rst_mid_level: got %0d expected 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_overflow: got %b expected 0", overflow); end
        checks++; if (wdt_timeout !== 1'b0) begin errors++; $display("FAIL rst_mid_wdt: got %b expected 0", wdt_timeout); end
        wdt_limit = '0; rst = 1'b0; tick;
        checks++; if (level !== 5'd1) begin errors++; $display("FAIL retrace_level: got %0d expected 1", level); end
        checks++; if (rd_data !== ent(1'b0, 1'b0, 24'd0, 4'h3)) begin errors++; $display("FAIL retrace_entry: got %h expected %h", rd_data, ent(1'b0, 1'b0, 24'd0, 4'h3)); end
    endtask

    initial begin
        rst_w = 1'b1; en_w = 1'b0; rd_ready_w = 1'b0;
        test_reset;
        test_basic;
        test_enable;
        test_mask;
        test_overflow;
        test_wrap;
        test_watchdog_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 ns, required completion earlier");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire

// File: doc/gpio_trace_logger.md
# gpio_trace_logger

Parametrised hardware trace unit that timestamps every change on a masked set of GPIO lines and buffers the events in a FIFO for readout over a valid/ready port. It also contains an inactivity watchdog. It sits beside the SoC GPIO block, sampling `gpio_dout`. It replaces the simulation-only LED-wave file logging and watchdog with a synthesizable, generalised equivalent usable on silicon and FPGA.

## Interface
- `WIDTH`, 4, number of traced GPIO lines (1..32)
- `DEPTH`, 16, FIFO entries; power of two, >= 2
- `TS_WIDTH`, 24, timestamp counter width
- `WDT_WIDTH`, 32, watchdog counter/limit width
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `en`  in  1  tracing enable
- `gpio_in`  in  WIDTH  traced lines, synchronous to `clk`
- `mask`  in  WIDTH  per-line trace enable; masked lines read as 0
- `wdt_limit`  in  WDT_WIDTH  inactivity limit in cycles; 0 disables the watchdog
- `clr`  in  1  one-cycle pulse that clears `overflow`, `wdt_timeout` and the watchdog counter
- `rd_valid`  out  1  FIFO head is valid
- `rd_ready`  in  1  consumer accepts the head
- `rd_data`  out  WIDTH+TS_WIDTH+2  head entry, packed as {lost, wrap, ts, gpio}
- `level`  out  $clog2(DEPTH+1)  current FIFO occupancy
- `overflow`  out  1  sticky flag: at least one event was dropped
- `wdt_timeout`  out  1  sticky flag: watchdog expired

## Operation
- Internal state:
  - `ts_q` timestamp
  - `prev_q` last recorded masked value
  - `first_q` flag
  - `lost_q` pending-loss flag
  - `wdt_q` watchdog counter
  - FIFO read/write pointers and count
- Let `cur = gpio_in & mask`.
- Event condition at an edge with `en`=1: `first_q` | (`cur` != `prev_q`) | (`ts_q` == all-ones).
- On an event:
  - Form the entry {`lost_q`, wrap, `ts_q`, `cur`}. The wrap bit is 1 iff `ts_q` == all-ones.
  - `prev_q` <= `cur`; `first_q` <= 0.
- Push rule:
  - If the FIFO is not full, or a pop occurs on the same edge, the entry is written and `lost_q` <= 0.
  - Otherwise the entry is dropped, `lost_q` <= 1 and `overflow` <= 1.
- Timestamp:
  - `ts_q` increments every edge with `en`=1 and wraps from all-ones to 0.
  - It holds while `en`=0.
- While `en`=0:
  - No events are generated.
  - `first_q` <= 1, so re-enabling always records the current state.
- Pop: an edge with `rd_valid`=1 and `rd_ready`=1 removes the head. `rd_ready` while empty has no effect.
- Simultaneous push and pop:
  - When full: both take effect and `level` stays at DEPTH.
  - When empty: the entry is written and `level` becomes 1.
- Watchdog:
  - While `en`=1, `wdt_q` resets to 0 on any event caused by a line change or `first_q`, otherwise it increments.
  - Wrap-only events do not reset `wdt_q`.
  - `wdt_q` saturates at all-ones and holds while `en`=0.
  - `wdt_timeout` <= 1 when `wdt_limit` != 0 and `wdt_q` >= `wdt_limit`. It stays set until `clr` or `rst`.
- `clr` priority: `clr` zeroes `overflow`, `wdt_timeout` and `wdt_q` on that edge. A drop on the same edge still sets `overflow`, so set wins over clear. The FIFO contents are untouched.
- Reset (`rst`=1 at an edge, including mid-trace):
  - FIFO is emptied.
  - `ts_q`, `prev_q`, `lost_q`, `wdt_q`, `overflow`, `wdt_timeout` <= 0; `first_q` <= 1.
  - `rst` overrides every other input.

## Timing
- All outputs are registered, except `rd_data`, which is the FIFO head and changes only on the edge after a pop or the first push.
- Reset values: `rd_valid`=0, `level`=0, `overflow`=0, `wdt_timeout`=0. `rd_data` is don't-care while `rd_valid`=0.
- Latency: a change present at edge k is in the FIFO after edge k. `rd_valid`=1 and `level` are updated in the cycle following edge k. The recorded `ts` equals the `ts_q` value before edge k.
- Throughput: one push and one pop per cycle. Back-to-back changes on consecutive cycles are all recorded while space remains.
- `wdt_timeout` rises one cycle after the edge at which `wdt_q` reaches `wdt_limit`.

## Test plan
- Basic trace: reset, mask=4'hF, en=1, `gpio_in`=4'h0; drive 4'h5 at cycle 10 and 4'hA at cycle 20.
  - Expect three entries: {0,0,0,4'h0}, {0,0,10,4'h5}, {0,0,20,4'hA}.
  - `level`=3.
- Mask: mask=4'h1, toggle `gpio_in`[3:1] every cycle for 50 cycles.
  - Expect only the initial entry; the watchdog counter is not reset.
- Overflow: DEPTH=16, `rd_ready`=0, 20 consecutive changes.
  - Expect `level`=16 and `overflow`=1.
  - Pop one entry, make one further change: the new entry has lost=1.
  - The next entry after that has lost=0.
- Full push/pop: with the FIFO full, change `gpio_in` and assert `rd_ready` on the same edge.
  - Expect no drop, `level` stays 16, `overflow` unchanged.
- Timestamp wrap: TS_WIDTH=4, static input.
  - Expect wrap entries at ts=15, 31-cycle spacing absent, i.e. one entry every 16 cycles with wrap=1.
- Watchdog and reset: `wdt_limit`=100, static input.
  - `wdt_timeout` rises at cycle 101 after the initial event.
  - `clr` drops it.
  - Assert `rst` mid-trace: all outputs return to 0 on the next cycle, and re-trace starts with a first entry at ts=0.
